// File: rtl/svga_sync.sv
// -----------------------------------------------------------------------------
// svga_sync
// Raster timing generator for an 800x600 @ 72 Hz SVGA display running at one
// pixel per 50 MHz clock. A horizontal pixel counter and a vertical line
// counter are kept in registers; every output is a zero-latency decode of
// those two counters, so hsync, vsync, video_enable and the coordinates all
// describe the same pixel in the same cycle.
//
// Ports:
//   clock        in   1   pixel clock, rising edge
//   reset        in   1   asynchronous, active-high; clears both counters
//   hsync        out  1   horizontal sync (HSYNC_POL while asserted)
//   vsync        out  1   vertical sync   (VSYNC_POL while asserted)
//   video_enable out  1   high while the current pixel is in the visible area
//   pixel_x      out  11  current horizontal position, 0..H_TOTAL-1
//   pixel_y      out  10  current vertical position,   0..V_TOTAL-1
// -----------------------------------------------------------------------------
module svga_sync #(
   parameter int   H_ACTIVE  = 800,
   parameter int   H_FP      = 56,
   parameter int   H_SYNC    = 120,
   parameter int   H_BP      = 64,
   parameter int   V_ACTIVE  = 600,
   parameter int   V_FP      = 37,
   parameter int   V_SYNC    = 6,
   parameter int   V_BP      = 23,
   parameter logic HSYNC_POL = 1'b1,
   parameter logic VSYNC_POL = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   output logic        hsync,
   output logic        vsync,
   output logic        video_enable,
   output logic [10:0] pixel_x,
   output logic [9:0]  pixel_y
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
   localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_ACT_END  = 10'(V_ACTIVE);
   localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [10:0] h_cnt_q, h_cnt_d;
   logic [9:0]  v_cnt_q, v_cnt_d;
   logic        hs_window_s;
   logic        vs_window_s;

   // Next-state logic for the pixel and line counters.
   // The wrap tests use >= rather than == so that a counter corrupted past its
   // last legal value is pulled straight back to 0 instead of running away;
   // for every legal count the behaviour is identical to an equality wrap.
   always_comb begin
      h_cnt_d = h_cnt_q + 11'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q >= H_LAST) begin
         h_cnt_d = 11'd0;
         if (v_cnt_q >= V_LAST) begin
            v_cnt_d = 10'd0;
         end else begin
            v_cnt_d = v_cnt_q + 10'd1;
         end
      end else begin
         v_cnt_d = v_cnt_q;
      end
   end

   // Counter registers with asynchronous clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         h_cnt_q <= 11'd0;
         v_cnt_q <= 10'd0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // Zero-latency output decode of the current counter values.
   always_comb begin
      hs_window_s  = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
      vs_window_s  = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
      hsync        = hs_window_s ? HSYNC_POL : ~HSYNC_POL;
      vsync        = vs_window_s ? VSYNC_POL : ~VSYNC_POL;
      video_enable = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
      pixel_x      = h_cnt_q;
      pixel_y      = v_cnt_q;
   end

endmodule

// File: tb/tb_svga_sync.sv
// -----------------------------------------------------------------------------
// tb_svga_sync
// Self-checking bench for svga_sync. Two instances share clock and reset:
//   u_big   - the real 800x600 timing (line-level behaviour, hsync, line wrap)
//   u_small - a shrunken raster (15 x 10) with active-low hsync, so that whole
//             frames, vsync and the end-of-frame wrap are covered quickly.
// The reference model counts clocks since reset release and derives the raster
// position by division/modulo, then applies the timing rules to it.
// -----------------------------------------------------------------------------
module tb_svga_sync;

   // Shrunken geometry for the second instance
   localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;   // 15 clocks per line
   localparam int S_VA = 5, S_VF = 2, S_VS = 2, S_VB = 1;   // 10 lines per frame
   localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
   localparam int S_VT = S_VA + S_VF + S_VS + S_VB;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        b_hs, b_vs, b_ve;
   logic [10:0] b_x;
   logic [9:0]  b_y;
   logic        s_hs, s_vs, s_ve;
   logic [10:0] s_x;
   logic [9:0]  s_y;

   int  compared   = 0;
   int  mismatched = 0;
   bit  cmp_en     = 1'b0;
   longint n_q;                    // clocks since the last reset release

   always #5 clk = ~clk;

   svga_sync u_big (
      .clock(clk), .reset(rst), .hsync(b_hs), .vsync(b_vs),
      .video_enable(b_ve), .pixel_x(b_x), .pixel_y(b_y)
   );

   svga_sync #(
      .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
      .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b1)
   ) u_small (
      .clock(clk), .reset(rst), .hsync(s_hs), .vsync(s_vs),
      .video_enable(s_ve), .pixel_x(s_x), .pixel_y(s_y)
   );

   // Elapsed-clock reference: cleared asynchronously by reset like the DUT.
   always @(posedge clk or posedge rst) begin
      if (rst) n_q <= 0;
      else     n_q <= n_q + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         if (mismatched <= 40)
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Compare one instance against the raster rules for a given geometry.
   task automatic check_raster(input string tag, input longint n,
                               input int ha, input int hf, input int hs, input int hb,
                               input int va, input int vf, input int vs, input int vb,
                               input bit hpol, input bit vpol,
                               input logic [10:0] x, input logic [9:0] y,
                               input logic ve, input logic hso, input logic vso);
      int ht, vt, ex, ey;
      bit eve, ehs, evs;
      ht  = ha + hf + hs + hb;
      vt  = va + vf + vs + vb;
      ex  = int'(n % ht);
      ey  = int'((n / ht) % vt);
      eve = (ex < ha) && (ey < va);
      ehs = (ex >= ha + hf && ex < ha + hf + hs) ? hpol : !hpol;
      evs = (ey >= va + vf && ey < va + vf + vs) ? vpol : !vpol;
      check({tag, ".pixel_x"},      32'(x),   32'(ex));
      check({tag, ".pixel_y"},      32'(y),   32'(ey));
      check({tag, ".video_enable"}, 32'(ve),  32'(eve));
      check({tag, ".hsync"},        32'(hso), 32'(ehs));
      check({tag, ".vsync"},        32'(vso), 32'(evs));
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         check_raster("big", n_q, 800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1,
                      b_x, b_y, b_ve, b_hs, b_vs);
         check_raster("small", n_q, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB,
                      1'b0, 1'b1, s_x, s_y, s_ve, s_hs, s_vs);
      end
   end

   // Directed stimulus and hand-computed expectations.
   initial begin
      int  b_hs_high, b_rise0, b_rise1, s_ve_cnt, s_vs_cnt;
      logic b_hs_prev, s_vs_prev;
      b_hs_high = 0; b_rise0 = -1; b_rise1 = -1; s_ve_cnt = 0; s_vs_cnt = 0;

      #1 rst = 1'b1;
      @(negedge clk);
      cmp_en = 1'b1;
      @(negedge clk);
      check("reset.pixel_x", 32'(b_x), 32'd0);
      check("reset.pixel_y", 32'(b_y), 32'd0);
      check("reset.video_enable", 32'(b_ve), 32'd1);
      check("reset.hsync", 32'(b_hs), 32'd0);
      check("reset.vsync", 32'(b_vs), 32'd0);
      check("reset.small_hsync", 32'(s_hs), 32'd1);

      rst = 1'b0;
      b_hs_prev = b_hs;
      s_vs_prev = s_vs;
      // 2580 clocks lands the big raster at (500,2)
      for (int i = 1; i <= 2580; i++) begin
         @(negedge clk);
         if (i == 1) begin
            check("first.pixel_x", 32'(b_x), 32'd1);
            check("first.pixel_y", 32'(b_y), 32'd0);
         end
         if (i == 855)  check("hs.before", 32'(b_hs), 32'd0);
         if (i == 856)  check("hs.start",  32'(b_hs), 32'd1);
         if (i == 975)  check("hs.last",   32'(b_hs), 32'd1);
         if (i == 976)  check("hs.end",    32'(b_hs), 32'd0);
         if (i == 1039) begin
            check("eol.pixel_x", 32'(b_x), 32'd1039);
            check("eol.pixel_y", 32'(b_y), 32'd0);
         end
         if (i == 1040) begin
            check("wrap.pixel_x", 32'(b_x), 32'd0);
            check("wrap.pixel_y", 32'(b_y), 32'd1);
         end
         if (i < 1040 && b_hs) b_hs_high++;
         if (b_hs && !b_hs_prev) begin
            if (b_rise0 < 0) b_rise0 = i;
            else if (b_rise1 < 0) b_rise1 = i;
         end
         // Small raster: second frame spans clocks 150..299
         if (i == 149) begin
            check("s.eof.pixel_x", 32'(s_x), 32'd14);
            check("s.eof.pixel_y", 32'(s_y), 32'd9);
         end
         if (i == 150) begin
            check("s.wrap.pixel_x", 32'(s_x), 32'd0);
            check("s.wrap.pixel_y", 32'(s_y), 32'd0);
            check("s.wrap.video_enable", 32'(s_ve), 32'd1);
         end
         if (i == 160) check("s.hs.low",  32'(s_hs), 32'd0);
         if (i == 163) check("s.hs.high", 32'(s_hs), 32'd1);
         if (i >= 150 && i < 300) begin
            if (s_ve) s_ve_cnt++;
            if (s_vs) s_vs_cnt++;
            if (s_vs && !s_vs_prev) begin
               check("s.vs.rise_x", 32'(s_x), 32'd0);
               check("s.vs.rise_y", 32'(s_y), 32'd7);
            end
         end
         b_hs_prev = b_hs;
         s_vs_prev = s_vs;
      end
      check("hs.width", 32'(b_hs_high), 32'd120);
      check("hs.period", 32'(b_rise1 - b_rise0), 32'd1040);
      check("s.ve.count", 32'(s_ve_cnt), 32'd40);
      check("s.vs.width", 32'(s_vs_cnt), 32'd30);
      check("pre_reset.pixel_x", 32'(b_x), 32'd500);
      check("pre_reset.pixel_y", 32'(b_y), 32'd2);

      // Asynchronous reset between clock edges, mid-line
      #2 rst = 1'b1;
      #1;
      check("async.pixel_x", 32'(b_x), 32'd0);
      check("async.pixel_y", 32'(b_y), 32'd0);
      check("async.hsync", 32'(b_hs), 32'd0);
      check("async.vsync", 32'(b_vs), 32'd0);
      check("async.video_enable", 32'(b_ve), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("resume.pixel_x", 32'(b_x), 32'd1);
      check("resume.pixel_y", 32'(b_y), 32'd0);
      repeat (200) @(negedge clk);
      cmp_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
